tour_move_seq: RTL and testbench
================================

# tour_move_seq

Sequencer between the tour solver and the command processor. On `start_tour` it walks the 24 solved moves by index. It splits each one-hot knight move into a vertical leg command and a horizontal leg command, then hands each command to the command processor using the same ready/clear handshake as the UART path. When idle, it passes UART commands straight through.

## Interface
- `NUM_MV`, default 24: number of moves; indices run 0..`NUM_MV`-1.
- `RESP_ACK`, default 8'hA5: response sent after an intermediate move.
- `RESP_DONE`, default 8'h5A: response sent after the final move.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_tour`  in  1  single-cycle pulse from the solver; the move table is valid.
- `move`  in  8  one-hot move read at `mv_indx`, valid one cycle after `mv_indx` changes.
- `mv_indx`  out  5  move table read index.
- `cmd_UART`  in  16  command from the UART wrapper.
- `cmd_rdy_UART`  in  1  UART command valid.
- `clr_cmd_rdy`  in  1  command processor has accepted `cmd`.
- `send_resp`  in  1  command processor has finished a command.
- `cmd`  out  16  muxed command to the command processor.
- `cmd_rdy`  out  1  muxed command valid.
- `clr_cmd_rdy_UART`  out  1  `clr_cmd_rdy` forwarded to UART while idle.
- `resp`  out  8  response byte to UART.
- `bad_move`  out  1  sticky non-one-hot move flag; always 0 without the macro.

## Operation
- Command fields: [15:12] opcode, [11:4] heading, [3:0] squares.
- Vertical leg command: opcode 4'h2, heading 8'h00 (N) or 8'h7F (S), squares |dy|.
- Horizontal leg command: opcode 4'h3 (move + fanfare), heading 8'hBF (E) or 8'h3F (W), squares |dx|.
- Move bit to (dx,dy):
  - b0 (+1,+2), b1 (−1,+2), b2 (−2,+1), b3 (−2,−1)
  - b4 (−1,−2), b5 (+1,−2), b6 (+2,−1), b7 (+2,+1)
- States: IDLE, FETCH, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`, `resp`=`RESP_ACK`. On `start_tour`: `mv_indx`←0, go to FETCH.
  - FETCH: one cycle for the table read latency; the decoded move is registered. Go to VERT.
  - VERT: `cmd_rdy`=1 with the vertical command. On `clr_cmd_rdy`, go to WAIT_V.
  - WAIT_V: on `send_resp`, go to HORZ. `resp`=`RESP_ACK`.
  - HORZ: `cmd_rdy`=1 with the horizontal command. On `clr_cmd_rdy`, go to WAIT_H.
  - WAIT_H: on `send_resp`:
    - if `mv_indx`==`NUM_MV`-1: go to IDLE, `resp`=`RESP_DONE` in that cycle;
    - else: `mv_indx`+1, go to FETCH, `resp`=`RESP_ACK`.
- Outside IDLE: `clr_cmd_rdy_UART`=0 and `cmd_UART` is ignored.
- `start_tour` outside IDLE is ignored.
- `send_resp` in VERT or HORZ is ignored; `clr_cmd_rdy` in a WAIT state is ignored.
- `mv_indx` holds its last value in IDLE and does not wrap.

## Timing
- Reset values: state IDLE, `mv_indx`=0, `bad_move`=0. Outputs then follow the IDLE mux.
- `start_tour` to first `cmd_rdy`: 2 cycles (IDLE→FETCH→VERT).
- `cmd` and `cmd_rdy` come from registers in tour states. The IDLE path is combinational from the UART inputs.
- `resp` is registered and updates in the cycle after the final `send_resp`.
- A `rst` asserted mid-tour returns the block to IDLE on the next edge. No command is reissued.

## Configuration
- `TOUR_MOVE_SEQ_CHK_EN` defined:
  - FETCH checks `move` with `$onehot`.
  - If the check fails: `bad_move`←1 (sticky until `rst`), the block returns to IDLE, and no command is issued.
- `TOUR_MOVE_SEQ_CHK_EN` undefined:
  - no check; `bad_move` is tied to 0;
  - a zero move decodes to b0, and multi-hot resolves to the lowest set bit.

## Structure
- Package `tour_pkg` contains:
  - opcode constants `OP_MOVE`=4'h2 and `OP_MOVE_FF`=4'h3;
  - heading constants `HDG_N`, `HDG_W`, `HDG_S`, `HDG_E`;
  - the `tour_seq_state_t` enum.
- Sub-module `tour_move_decode`: combinational. Maps `move[7:0]` to `{vert_cmd[15:0], horz_cmd[15:0]}`. It is instantiated once, feeding the FETCH register.

## Test plan
- Idle passthrough: `cmd_UART`=16'h2004 with `cmd_rdy_UART`=1 → `cmd`=16'h2004 and `cmd_rdy`=1 in the same cycle; `clr_cmd_rdy` pulse → `clr_cmd_rdy_UART` pulse; `resp`=8'hA5.
- Single decode: `move`=8'h01 → 16'h2002 (N 2), then 16'h3BF1 (E 1); `move`=8'h08 → 16'h27F1 (S 1), then 16'h33F2 (W 2).
- Handshake hold: `clr_cmd_rdy` withheld 50 cycles → `cmd` and `cmd_rdy` stable throughout; `send_resp` during VERT does not advance the state.
- Full tour: 24 moves with processor handshakes → 48 commands, `mv_indx` 0..23; `resp`=8'hA5 after moves 0–22 and 8'h5A after move 23; block back in IDLE.
- Reset mid-tour: `rst` in WAIT_H of move 5 → next cycle IDLE, `mv_indx`=0, `cmd_rdy` follows `cmd_rdy_UART`.
- With `TOUR_MOVE_SEQ_CHK_EN`: `move`=8'h03 → `bad_move`=1, no `cmd_rdy`, block in IDLE.

Source files
------------

// File: rtl/tour_move_seq_pkg.sv
// Shared constants and state type for the knight-tour move sequencer.
package tour_pkg;

   localparam logic [3:0] OP_MOVE    = 4'h2;
   localparam logic [3:0] OP_MOVE_FF = 4'h3;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      VERT,
      WAIT_V,
      HORZ,
      WAIT_H
   } tour_seq_state_t;

   function automatic logic is_onehot8(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into a vertical-leg and a horizontal-leg command.
// Zero decodes as bit 0; multi-hot resolves to the lowest set bit.
module tour_move_decode
   import tour_pkg::*;
(
   input  logic [7:0]  move_i,
   output logic [15:0] vert_cmd_o,
   output logic [15:0] horz_cmd_o
);

   always_comb begin
      vert_cmd_o = {OP_MOVE,    HDG_N, 4'd2};
      horz_cmd_o = {OP_MOVE_FF, HDG_E, 4'd1};
      if (!move_i[0]) begin
         if (move_i[1]) begin
            vert_cmd_o = {OP_MOVE,    HDG_N, 4'd2};
            horz_cmd_o = {OP_MOVE_FF, HDG_W, 4'd1};
         end else if (move_i[2]) begin
            vert_cmd_o = {OP_MOVE,    HDG_N, 4'd1};
            horz_cmd_o = {OP_MOVE_FF, HDG_W, 4'd2};
         end else if (move_i[3]) begin
            vert_cmd_o = {OP_MOVE,    HDG_S, 4'd1};
            horz_cmd_o = {OP_MOVE_FF, HDG_W, 4'd2};
         end else if (move_i[4]) begin
            vert_cmd_o = {OP_MOVE,    HDG_S, 4'd2};
            horz_cmd_o = {OP_MOVE_FF, HDG_W, 4'd1};
         end else if (move_i[5]) begin
            vert_cmd_o = {OP_MOVE,    HDG_S, 4'd2};
            horz_cmd_o = {OP_MOVE_FF, HDG_E, 4'd1};
         end else if (move_i[6]) begin
            vert_cmd_o = {OP_MOVE,    HDG_S, 4'd1};
            horz_cmd_o = {OP_MOVE_FF, HDG_E, 4'd2};
         end else if (move_i[7]) begin
            vert_cmd_o = {OP_MOVE,    HDG_N, 4'd1};
            horz_cmd_o = {OP_MOVE_FF, HDG_E, 4'd2};
         end
      end
   end

endmodule

// File: rtl/tour_move_seq.sv
// Walks the solved tour, issuing a vertical then horizontal leg per move; UART passthrough when idle.
// Optional one-hot move check enabled by defining TOUR_MOVE_SEQ_CHK_EN.
module tour_move_seq
   import tour_pkg::*;
#(
   parameter int          NUM_MV    = 24,
   parameter logic [7:0]  RESP_ACK  = 8'hA5,
   parameter logic [7:0]  RESP_DONE = 8'h5A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic        clr_cmd_rdy_UART,
   output logic [7:0]  resp,
   output logic        bad_move
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_MV - 1);

   tour_seq_state_t state_q, state_d;
   logic [4:0]  mv_indx_q, mv_indx_d;
   logic [7:0]  resp_q, resp_d;
   logic        cmd_rdy_q, cmd_rdy_d;
   logic [15:0] cmd_q, cmd_d;
   logic [15:0] vert_q, vert_d;
   logic [15:0] horz_q, horz_d;
   logic [15:0] vert_dec, horz_dec;
   logic        bad_set;

   tour_move_decode u_dec (
      .move_i     (move),
      .vert_cmd_o (vert_dec),
      .horz_cmd_o (horz_dec)
   );

   always_comb begin
      state_d   = state_q;
      mv_indx_d = mv_indx_q;
      resp_d    = resp_q;
      vert_d    = vert_q;
      horz_d    = horz_q;
      bad_set   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_tour) begin
               mv_indx_d = 5'd0;
               resp_d    = RESP_ACK;
               state_d   = FETCH;
            end
         end
         FETCH: begin
            vert_d  = vert_dec;
            horz_d  = horz_dec;
            state_d = VERT;
`ifdef TOUR_MOVE_SEQ_CHK_EN
            if (!is_onehot8(move)) begin
               bad_set = 1'b1;
               state_d = IDLE;
            end
`endif
         end
         VERT:   if (clr_cmd_rdy) state_d = WAIT_V;
         WAIT_V: begin
            if (send_resp) begin
               resp_d  = RESP_ACK;
               state_d = HORZ;
            end
         end
         HORZ:   if (clr_cmd_rdy) state_d = WAIT_H;
         WAIT_H: begin
            if (send_resp) begin
               if (mv_indx_q == LAST_IDX) begin
                  resp_d  = RESP_DONE;
                  state_d = IDLE;
               end else begin
                  resp_d    = RESP_ACK;
                  mv_indx_d = mv_indx_q + 5'd1;
                  state_d   = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Command registers are loaded from the next state so cmd/cmd_rdy leave flops.
      cmd_rdy_d = (state_d == VERT) || (state_d == HORZ);
      cmd_d     = cmd_q;
      if (state_d == VERT)      cmd_d = vert_d;
      else if (state_d == HORZ) cmd_d = horz_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mv_indx_q <= 5'd0;
         resp_q    <= RESP_ACK;
         cmd_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mv_indx_q <= mv_indx_d;
         resp_q    <= resp_d;
         cmd_rdy_q <= cmd_rdy_d;
      end
   end

   always_ff @(posedge clk) begin
      cmd_q  <= cmd_d;
      vert_q <= vert_d;
      horz_q <= horz_d;
   end

`ifdef TOUR_MOVE_SEQ_CHK_EN
   logic bad_move_q;
   always_ff @(posedge clk) begin
      if (rst)          bad_move_q <= 1'b0;
      else if (bad_set) bad_move_q <= 1'b1;
   end
   assign bad_move = bad_move_q;
`else
   logic unused_bad;
   assign unused_bad = bad_set;
   assign bad_move   = 1'b0;
`endif

   assign cmd              = (state_q == IDLE) ? cmd_UART     : cmd_q;
   assign cmd_rdy          = (state_q == IDLE) ? cmd_rdy_UART : cmd_rdy_q;
   assign clr_cmd_rdy_UART = (state_q == IDLE) & clr_cmd_rdy;
   assign resp             = resp_q;
   assign mv_indx          = mv_indx_q;

endmodule

// File: tb/tb_tour_move_seq.sv
// Directed bench for tour_move_seq with a command scoreboard and a combinational move table.
module tb_tour_move_seq;

   logic        clk = 1'b0;
   logic        rst, start_tour, cmd_rdy_UART, clr_cmd_rdy, send_resp;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART, cmd;
   logic        cmd_rdy, clr_cmd_rdy_UART, bad_move;
   logic [7:0]  resp;

   logic [7:0]  tab [24];
   logic [15:0] exp_q [$];
   int n_assert = 0;
   int n_fail   = 0;

   assign move = tab[mv_indx];

   always #5 clk = ~clk;

   tour_move_seq dut (
      .clk              (clk),
      .rst              (rst),
      .start_tour       (start_tour),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy      (clr_cmd_rdy),
      .send_resp        (send_resp),
      .cmd              (cmd),
      .cmd_rdy          (cmd_rdy),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .resp             (resp),
      .bad_move         (bad_move)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [7:0] m, output logic [15:0] v, output logic [15:0] h);
      int b = 0;
      int dx, dy;
      for (int i = 7; i >= 0; i--) if (m[i]) b = i;
      case (b)
         0: begin dx =  1; dy =  2; end
         1: begin dx = -1; dy =  2; end
         2: begin dx = -2; dy =  1; end
         3: begin dx = -2; dy = -1; end
         4: begin dx = -1; dy = -2; end
         5: begin dx =  1; dy = -2; end
         6: begin dx =  2; dy = -1; end
         default: begin dx = 2; dy = 1; end
      endcase
      v = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy > 0) ? dy : -dy)};
      h = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx > 0) ? dx : -dx)};
   endfunction

   task automatic push_tour(input int n);
      logic [15:0] v, h;
      for (int i = 0; i < n; i++) begin
         model(tab[i], v, h);
         exp_q.push_back(v);
         exp_q.push_back(h);
      end
   endtask

   // Wait for a command, compare it, optionally hold off acceptance, then accept it.
   task automatic issue(input string tag, input int hold);
      int k = 0;
      logic [15:0] e;
      while (cmd_rdy !== 1'b1 && k < 20) begin tick(); k++; end
      chk({tag, " rdy"}, {31'd0, cmd_rdy}, 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk({tag, " cmd"}, {16'd0, cmd}, {16'd0, e});
      for (int j = 0; j < hold; j++) begin
         if (j == hold / 2) send_resp = 1'b1;
         tick();
         send_resp = 1'b0;
         chk({tag, " hold_cmd"}, {16'd0, cmd}, {16'd0, e});
         chk({tag, " hold_rdy"}, {31'd0, cmd_rdy}, 32'd1);
      end
      clr_cmd_rdy = 1'b1;
      #1;
      chk({tag, " no_uart_clr"}, {31'd0, clr_cmd_rdy_UART}, 32'd0);
      tick();
      clr_cmd_rdy = 1'b0;
      chk({tag, " rdy_drop"}, {31'd0, cmd_rdy}, 32'd0);
   endtask

   task automatic serve(input string tag, input bit fin, input int hold);
      issue(tag, hold);
      start_tour  = 1'b1;
      clr_cmd_rdy = 1'b1;
      tick();
      start_tour  = 1'b0;
      clr_cmd_rdy = 1'b0;
      chk({tag, " wait_rdy"}, {31'd0, cmd_rdy}, 32'd0);
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk({tag, " resp"}, {24'd0, resp}, fin ? 32'h5A : 32'hA5);
   endtask

   task automatic begin_tour();
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      chk("fetch_no_rdy", {31'd0, cmd_rdy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start_tour = 1'b0; cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
      send_resp = 1'b0; cmd_UART = 16'h0000;
      for (int i = 0; i < 24; i++) tab[i] = 8'h01 << (i % 8);
      tab[1] = 8'h08;
      tick(); tick();
      rst = 1'b0;
      chk("rst_indx", {27'd0, mv_indx}, 32'd0);
      chk("rst_bad", {31'd0, bad_move}, 32'd0);
      chk("rst_resp", {24'd0, resp}, 32'hA5);
      chk("rst_rdy", {31'd0, cmd_rdy}, 32'd0);

      // Idle passthrough
      cmd_UART = 16'h2004; cmd_rdy_UART = 1'b1;
      #1;
      chk("pt_cmd", {16'd0, cmd}, 32'h2004);
      chk("pt_rdy", {31'd0, cmd_rdy}, 32'd1);
      clr_cmd_rdy = 1'b1;
      #1;
      chk("pt_clr", {31'd0, clr_cmd_rdy_UART}, 32'd1);
      tick();
      clr_cmd_rdy = 1'b0;
      #1;
      chk("pt_clr_low", {31'd0, clr_cmd_rdy_UART}, 32'd0);
      chk("pt_resp", {24'd0, resp}, 32'hA5);

      // Full tour, UART side held busy with a junk command
      cmd_UART = 16'hFFFF;
      exp_q.delete();
      push_tour(24);
      begin_tour();
      tick();
      chk("lat2_rdy", {31'd0, cmd_rdy}, 32'd1);
      for (int i = 0; i < 24; i++) begin
         serve($sformatf("mv%0d_v", i), 1'b0, (i == 0) ? 50 : 0);
         chk($sformatf("mv%0d_indx", i), {27'd0, mv_indx}, i);
         serve($sformatf("mv%0d_h", i), i == 23, 0);
      end
      chk("end_indx", {27'd0, mv_indx}, 32'd23);
      chk("end_sb", exp_q.size(), 32'd0);
      cmd_rdy_UART = 1'b0; cmd_UART = 16'h1234;
      #1;
      chk("end_idle_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("end_idle_cmd", {16'd0, cmd}, 32'h1234);
      tick();
      chk("end_resp_hold", {24'd0, resp}, 32'h5A);

      // Reset in WAIT_H of move 5
      cmd_rdy_UART = 1'b1;
      exp_q.delete();
      push_tour(24);
      begin_tour();
      for (int i = 0; i < 5; i++) begin
         serve($sformatf("r%0d_v", i), 1'b0, 0);
         serve($sformatf("r%0d_h", i), 1'b0, 0);
      end
      serve("r5_v", 1'b0, 0);
      issue("r5_h", 0);
      chk("r5_indx", {27'd0, mv_indx}, 32'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      chk("rst_mid_indx", {27'd0, mv_indx}, 32'd0);
      chk("rst_mid_rdy1", {31'd0, cmd_rdy}, 32'd1);
      cmd_rdy_UART = 1'b0;
      #1;
      chk("rst_mid_rdy0", {31'd0, cmd_rdy}, 32'd0);
      tick(); tick(); tick();
      chk("rst_mid_noreissue", {31'd0, cmd_rdy}, 32'd0);
      chk("rst_mid_resp", {24'd0, resp}, 32'hA5);

`ifdef TOUR_MOVE_SEQ_CHK_EN
      tab[0] = 8'h03;
      begin_tour();
      tick();
      chk("chk_bad", {31'd0, bad_move}, 32'd1);
      chk("chk_no_rdy", {31'd0, cmd_rdy}, 32'd0);
      cmd_rdy_UART = 1'b1;
      #1;
      chk("chk_idle", {31'd0, cmd_rdy}, 32'd1);
      cmd_rdy_UART = 1'b0;
      tick(); tick();
      chk("chk_sticky", {31'd0, bad_move}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("chk_clear", {31'd0, bad_move}, 32'd0);
`else
      // Zero move decodes to bit 0; multi-hot takes the lowest set bit
      tab[0] = 8'h00;
      exp_q.delete();
      push_tour(1);
      begin_tour();
      serve("zero_v", 1'b0, 0);
      serve("zero_h", 1'b0, 0);
      chk("zero_bad", {31'd0, bad_move}, 32'd0);
      rst = 1'b1; tick(); rst = 1'b0;
      tab[0] = 8'h0C;
      exp_q.delete();
      push_tour(1);
      begin_tour();
      serve("multi_v", 1'b0, 0);
      serve("multi_h", 1'b0, 0);
      chk("multi_bad", {31'd0, bad_move}, 32'd0);
      rst = 1'b1; tick(); rst = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
